// File: rtl/ssd_driver.sv
// ssd_driver: converts a 13-bit binary value to four BCD digits with a
// sequential double-dabble, then multiplexes them onto a common-anode
// 4-digit seven-segment display with optional leading-zero blanking.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting; captures value_i when it changed or a reload is pending
// S_CONV | 13 double-dabble iterations (add-3 on nibbles >= 5, then shift)
// S_DONE | publishes the BCD result on bcd_o and pulses conv_done_o

module ssd_driver #(
  parameter int REFRESH_CNT = 100000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value_i,
  output logic [3:0]  anode_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [15:0] bcd_o,
  output logic        conv_done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CNT - 1);
  localparam logic [3:0] LAST_ITER = 4'd12;

  // Conversion datapath and FSM state.
  state_t      state_q, state_d;
  logic [12:0] last_q, last_d;
  logic        pend_q, pend_d;
  logic [28:0] sh_q, sh_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  // Display multiplexer state.
  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0] nib;
  logic       blank;

  // One double-dabble iteration over {bcd[15:0], bin[12:0]}.
  function automatic logic [28:0] dd_step(input logic [28:0] s);
    logic [28:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[13 + 4*i +: 4] >= 4'd5) begin
        t[13 + 4*i +: 4] = t[13 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[27:0], 1'b0};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Conversion FSM and result registers; reset forces a reload via pend_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 13'd0;
      pend_q  <= 1'b1;
      sh_q    <= 29'd0;
      iter_q  <= 4'd0;
      bcd_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      sh_q    <= sh_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: capture in IDLE, iterate in CONV, publish in DONE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pend_d  = pend_q;
    sh_d    = sh_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((value_i != last_q) || pend_q) begin
          sh_d    = {16'd0, value_i};
          last_d  = value_i;
          pend_d  = 1'b0;
          iter_d  = 4'd0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sh_d   = dd_step(sh_q);
        iter_d = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = sh_q[28:13];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Refresh timer, digit index and registered anode/segment drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      dig_q     <= 2'd0;
      anode_q   <= 4'b1110;
      seg_q     <= 7'b1000000;
    end else begin
      refresh_q <= refresh_d;
      dig_q     <= dig_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  // Digit selection, leading-zero blanking and segment decode.
  always_comb begin
    refresh_d = refresh_q + CW'(1);
    dig_d     = dig_q;
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      dig_d     = dig_q + 2'd1;
    end

    nib   = bcd_q[3:0];
    blank = 1'b0;
    case (dig_q)
      2'd0: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = (bcd_q[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        blank = (bcd_q[15:8] == 8'd0);
      end
      default: begin
        nib   = bcd_q[15:12];
        blank = (bcd_q[15:12] == 4'd0);
      end
    endcase

    if (BLANK_LEAD && blank) begin
      anode_d = 4'b1111;
      seg_d   = 7'b1111111;
    end else begin
      anode_d = ~(4'b0001 << dig_q);
      seg_d   = seg_lut(nib);
    end
  end

  assign anode_o     = anode_q;
  assign seg_o       = seg_q;
  assign dp_o        = 1'b1;
  assign bcd_o       = bcd_q;
  assign conv_done_o = done_q;

endmodule

// File: tb/tb_ssd_driver.sv
// Directed bench for ssd_driver: conversion latency, BCD results, done-pulse
// width, reset abort and the multiplexed/blanked display sequence.

module tb_ssd_driver;

  logic        clk;
  logic        rst;
  logic [12:0] value_i;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [15:0] bcd_o;
  logic        conv_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  ssd_driver #(
    .REFRESH_CNT(4),
    .BLANK_LEAD (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .anode_o    (anode_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .bcd_o      (bcd_o),
    .conv_done_o(conv_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts rising edges from the current negedge until conv_done_o is seen;
  // returns -1 if it never arrives within the budget.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (conv_done_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_width"}, 32'(conv_done_o), 32'd0);
  endtask

  // Aligns on the digit-0 slot, then checks 5 slots x 4 cycles:
  // digits 0,1,2,3 and digit 0 again.
  task automatic check_display(input string tag, input logic [15:0] an_exp,
                               input logic [27:0] seg_exp);
    logic [3:0] prev;
    bit         found;
    int         d;
    prev  = anode_o;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (anode_o == 4'b1110 && prev != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = anode_o;
    end
    check_eq({tag, "_sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int s = 0; s < 5; s++) begin
        d = s % 4;
        for (int c = 0; c < 4; c++) begin
          if (s != 0 || c != 0) @(negedge clk);
          check_eq($sformatf("%s_anode_d%0d_c%0d", tag, d, c), 32'(anode_o),
                   32'(an_exp[d*4 +: 4]));
          check_eq($sformatf("%s_seg_d%0d_c%0d", tag, d, c), 32'(seg_o),
                   32'(seg_exp[d*7 +: 7]));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst     = 1'b1;
    value_i = 13'd0;

    // Reset held two cycles, value 0.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bcd",   32'(bcd_o),       32'h0000);
    check_eq("rst_done",  32'(conv_done_o), 32'd0);
    check_eq("rst_anode", 32'(anode_o),     32'hE);
    check_eq("rst_seg",   32'(seg_o),       32'h40);
    check_eq("rst_dp",    32'(dp_o),        32'd1);
    rst = 1'b0;
    wait_done(n);
    check_eq("zero_latency", 32'(n), 32'd15);
    check_eq("zero_bcd", 32'(bcd_o), 32'h0000);
    check_pulse_end("zero");
    check_display("zero", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Full-scale value, no blanking.
    value_i = 13'd8191;
    wait_done(n);
    check_eq("max_latency", 32'(n), 32'd15);
    check_eq("max_bcd", 32'(bcd_o), 32'h8191);
    check_pulse_end("max");
    check_display("max", 16'h7BDE, {7'h00, 7'h79, 7'h10, 7'h79});

    // Digit scan order with REFRESH_CNT=4.
    value_i = 13'd1234;
    wait_done(n);
    check_eq("scan_latency", 32'(n), 32'd15);
    check_eq("scan_bcd", 32'(bcd_o), 32'h1234);
    check_pulse_end("scan");
    check_display("scan", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});
    check_eq("scan_bcd_hold", 32'(bcd_o), 32'h1234);

    // Internal zeros stay lit.
    value_i = 13'd1005;
    wait_done(n);
    check_eq("izero_latency", 32'(n), 32'd15);
    check_eq("izero_bcd", 32'(bcd_o), 32'h1005);
    check_pulse_end("izero");
    check_display("izero", 16'h7BDE, {7'h79, 7'h40, 7'h40, 7'h12});

    // value_i changes to 42 during the 5th CONV cycle (between E4 and E5).
    value_i = 13'd1234;
    repeat (5) @(posedge clk);
    @(negedge clk);
    value_i = 13'd42;
    wait_done(n);
    check_eq("chg_first_latency", 32'(n + 5), 32'd15);
    check_eq("chg_first_bcd", 32'(bcd_o), 32'h1234);
    wait_done(n);
    check_eq("chg_second_latency", 32'(n), 32'd15);
    check_eq("chg_second_bcd", 32'(bcd_o), 32'h0042);
    check_pulse_end("chg");
    check_display("blank", 16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h24});

    // Reset in the middle of a conversion.
    value_i = 13'd1005;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("abort_bcd_hold", 32'(bcd_o), 32'h0042);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_bcd",   32'(bcd_o),       32'h0000);
    check_eq("abort_done",  32'(conv_done_o), 32'd0);
    check_eq("abort_anode", 32'(anode_o),     32'hE);
    check_eq("abort_seg",   32'(seg_o),       32'h40);
    rst = 1'b0;
    wait_done(n);
    check_eq("abort_latency", 32'(n), 32'd15);
    check_eq("abort_bcd_final", 32'(bcd_o), 32'h1005);
    check_pulse_end("abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
